// File: rtl/chimp_grid_engine.sv
// Chimp-test board engine: clears the board, scatters tiles 1..cnt,
// checks in-order clicks and serves a registered read port to the renderer.
module chimp_grid_engine #(
    parameter int GRID_W    = 8,
    parameter int GRID_H    = 8,
    parameter int NUM_W     = 5,
    parameter int RAND_W    = 8,
    parameter int RETRY_MAX = 15,
    localparam int XW = $clog2(GRID_W),
    localparam int YW = $clog2(GRID_H)
) (
    input  logic              clk,
    input  logic              iResetn,
    input  logic              iStart,
    input  logic [NUM_W-1:0]  iCount,
    input  logic [RAND_W-1:0] iRandNum,
    input  logic              iClickValid,
    input  logic [XW-1:0]     iClickX,
    input  logic [YW-1:0]     iClickY,
    input  logic [XW-1:0]     iRdX,
    input  logic [YW-1:0]     iRdY,
    output logic              oRdActive,
    output logic              oRdShown,
    output logic [NUM_W-1:0]  oRdNum,
    output logic              oBusy,
    output logic [2:0]        oState,
    output logic [NUM_W-1:0]  oNextNum,
    output logic              oCorrect,
    output logic              oWrong,
    output logic              oWon,
    output logic              oLost
);

    localparam int NC   = GRID_W * GRID_H;
    localparam int IW   = $clog2(NC);
    localparam int NMAX = (1 << NUM_W) - 1;
    localparam int CMAX = (NC < NMAX) ? NC : NMAX;
    localparam int RTW  = $clog2(RETRY_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_LOAD   = 3'd2,
        S_SHOW   = 3'd3,
        S_HIDDEN = 3'd4,
        S_WON    = 3'd5,
        S_LOST   = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic             act_q [NC];
    logic [NUM_W-1:0] num_q [NC];
    logic [NUM_W-1:0] cnt_q, next_q, tile_q;
    logic [RTW-1:0]   retry_q;
    logic [IW-1:0]    clr_q;
    logic             correct_q, wrong_q;
    logic             rd_act_q, rd_shown_q;
    logic [NUM_W-1:0] rd_num_q;

    logic [XW-1:0]    draw_x;
    logic [YW-1:0]    draw_y;
    logic [IW-1:0]    draw_idx, free_idx, place_idx, click_idx, rd_idx;
    logic             draw_ok, click_in, click_hit, rd_in;
    logic             place, click_good, click_bad;
    logic [NUM_W-1:0] click_num;
    logic             unused_rand;

    function automatic logic [IW-1:0] cell_idx(input logic [XW-1:0] x,
                                               input logic [YW-1:0] y);
        return IW'(int'(y) * GRID_W + int'(x));
    endfunction

    function automatic logic [NUM_W-1:0] clamp_cnt(input logic [NUM_W-1:0] c);
        if (c == '0)
            return NUM_W'(1);
        if (int'(c) > CMAX)
            return NUM_W'(CMAX);
        return c;
    endfunction

    assign unused_rand = ^{1'b0, iRandNum};

    assign draw_x   = iRandNum[XW-1:0];
    assign draw_y   = iRandNum[XW+YW-1:XW];
    assign draw_idx = cell_idx(draw_x, draw_y);
    assign draw_ok  = (int'(draw_x) < GRID_W) && (int'(draw_y) < GRID_H)
                      && !act_q[draw_idx];

    assign click_idx = cell_idx(iClickX, iClickY);
    assign click_in  = (int'(iClickX) < GRID_W) && (int'(iClickY) < GRID_H);
    assign click_hit = iClickValid && click_in && act_q[click_idx];
    assign click_num = num_q[click_idx];

    assign rd_idx = cell_idx(iRdX, iRdY);
    assign rd_in  = (int'(iRdX) < GRID_W) && (int'(iRdY) < GRID_H);

    // Lowest-index free cell, used when random draws keep missing
    always_comb begin
        free_idx = '0;
        for (int i = NC - 1; i >= 0; i--)
            if (!act_q[i])
                free_idx = IW'(i);
    end

    // Next-state decode plus placement and click decisions
    always_comb begin
        state_d    = state_q;
        place      = 1'b0;
        place_idx  = draw_idx;
        click_good = 1'b0;
        click_bad  = 1'b0;
        if (iStart) begin
            state_d = S_CLEAR;
        end else begin
            unique case (state_q)
                S_CLEAR: begin
                    if (clr_q == IW'(NC - 1))
                        state_d = S_LOAD;
                end
                S_LOAD: begin
                    if (draw_ok) begin
                        place = 1'b1;
                    end else if (retry_q == RTW'(RETRY_MAX - 1)) begin
                        place     = 1'b1;
                        place_idx = free_idx;
                    end
                    if (place && tile_q == cnt_q)
                        state_d = S_SHOW;
                end
                S_SHOW, S_HIDDEN: begin
                    if (click_hit) begin
                        if (click_num == next_q) begin
                            click_good = 1'b1;
                            state_d = (click_num == cnt_q) ? S_WON : S_HIDDEN;
                        end else begin
                            click_bad = 1'b1;
                            state_d   = S_LOST;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge iResetn) begin
        if (!iResetn)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Board storage, round counters, click pulses and read port
    always_ff @(posedge clk or negedge iResetn) begin
        if (!iResetn) begin
            for (int i = 0; i < NC; i++) begin
                act_q[i] <= 1'b0;
                num_q[i] <= '0;
            end
            cnt_q      <= '0;
            next_q     <= NUM_W'(1);
            tile_q     <= NUM_W'(1);
            retry_q    <= '0;
            clr_q      <= '0;
            correct_q  <= 1'b0;
            wrong_q    <= 1'b0;
            rd_act_q   <= 1'b0;
            rd_shown_q <= 1'b0;
            rd_num_q   <= '0;
        end else begin
            correct_q  <= click_good;
            wrong_q    <= click_bad;
            rd_act_q   <= rd_in && act_q[rd_idx];
            rd_shown_q <= rd_in && act_q[rd_idx]
                          && (state_q == S_SHOW || state_q == S_LOST);
            rd_num_q   <= rd_in ? num_q[rd_idx] : '0;
            if (iStart) begin
                cnt_q   <= clamp_cnt(iCount);
                next_q  <= NUM_W'(1);
                tile_q  <= NUM_W'(1);
                retry_q <= '0;
                clr_q   <= '0;
            end else begin
                if (state_q == S_CLEAR) begin
                    act_q[clr_q] <= 1'b0;
                    num_q[clr_q] <= '0;
                    clr_q        <= clr_q + 1'b1;
                end
                if (state_q == S_LOAD) begin
                    if (place) begin
                        act_q[place_idx] <= 1'b1;
                        num_q[place_idx] <= tile_q;
                        tile_q           <= tile_q + 1'b1;
                        retry_q          <= '0;
                    end else begin
                        retry_q <= retry_q + 1'b1;
                    end
                end
                if (click_good) begin
                    act_q[click_idx] <= 1'b0;
                    next_q           <= next_q + 1'b1;
                end
            end
        end
    end

    assign oRdActive = rd_act_q;
    assign oRdShown  = rd_shown_q;
    assign oRdNum    = rd_num_q;
    assign oBusy     = (state_q == S_CLEAR) || (state_q == S_LOAD);
    assign oState    = state_q;
    assign oNextNum  = next_q;
    assign oCorrect  = correct_q;
    assign oWrong    = wrong_q;
    assign oWon      = (state_q == S_WON);
    assign oLost     = (state_q == S_LOST);

endmodule

// File: tb/tb_chimp_grid_engine.sv
// Scoreboard bench for chimp_grid_engine: an 8x8 board driven against a
// placement model, plus a 4x4 board for the tile-count clamp.
module tb_chimp_grid_engine;

    localparam int NC = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       iStart, iClickValid;
    logic [4:0] iCount;
    logic [7:0] iRandNum;
    logic [2:0] iClickX, iClickY, iRdX, iRdY;
    logic       oRdActive, oRdShown, oBusy, oCorrect, oWrong, oWon, oLost;
    logic [4:0] oRdNum, oNextNum;
    logic [2:0] oState;

    logic       s_start;
    logic [4:0] s_count;
    logic [7:0] s_rand;
    logic [1:0] s_rdx, s_rdy;
    logic       s_rdact, s_rdshown, s_busy, s_cor, s_wr, s_won, s_lost;
    logic [4:0] s_rdnum, s_next;
    logic [2:0] s_state;

    always #5 clk = ~clk;

    chimp_grid_engine u_dut (
        .clk(clk), .iResetn(rst_n), .iStart(iStart), .iCount(iCount),
        .iRandNum(iRandNum), .iClickValid(iClickValid),
        .iClickX(iClickX), .iClickY(iClickY), .iRdX(iRdX), .iRdY(iRdY),
        .oRdActive(oRdActive), .oRdShown(oRdShown), .oRdNum(oRdNum),
        .oBusy(oBusy), .oState(oState), .oNextNum(oNextNum),
        .oCorrect(oCorrect), .oWrong(oWrong), .oWon(oWon), .oLost(oLost)
    );

    chimp_grid_engine #(.GRID_W(4), .GRID_H(4)) u_small (
        .clk(clk), .iResetn(rst_n), .iStart(s_start), .iCount(s_count),
        .iRandNum(s_rand), .iClickValid(1'b0),
        .iClickX(2'd0), .iClickY(2'd0), .iRdX(s_rdx), .iRdY(s_rdy),
        .oRdActive(s_rdact), .oRdShown(s_rdshown), .oRdNum(s_rdnum),
        .oBusy(s_busy), .oState(s_state), .oNextNum(s_next),
        .oCorrect(s_cor), .oWrong(s_wr), .oWon(s_won), .oLost(s_lost)
    );

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    bit   m_act [NC];
    int   m_num [NC];
    int   pos [32];
    int   m_cnt;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] got);
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check(e.tag, got, e.exp);
        end
    endtask

    task automatic click(input int idx, input bit c, input bit w,
                         input string tag);
        iClickX     = 3'(idx % 8);
        iClickY     = 3'(idx / 8);
        iClickValid = 1'b1;
        sb_push(tag, {30'b0, c, w});
        step();
        iClickValid = 1'b0;
        sb_pop({30'b0, oCorrect, oWrong});
        if (c)
            m_act[idx] = 1'b0;
    endtask

    task automatic rd(input int idx, input bit vis, input string tag);
        logic [31:0] e;
        e = {25'b0, m_act[idx], m_act[idx] & vis, 5'(m_num[idx])};
        iRdX = 3'(idx % 8);
        iRdY = 3'(idx / 8);
        sb_push(tag, e);
        step();
        sb_pop({25'b0, oRdActive, oRdShown, oRdNum});
    endtask

    task automatic rd_all(input bit vis);
        for (int i = 0; i < NC; i++)
            rd(i, vis, "rd_cell");
    endtask

    // mode 0: random draws, mode 1: draws stuck on cell 5
    task automatic start_round(input int count, input int mode,
                               input int click_idx);
        int n, k, retry, cyc, idx, pidx;
        logic [7:0] r;
        iCount = 5'(count);
        iStart = 1'b1;
        if (click_idx >= 0) begin
            iClickValid = 1'b1;
            iClickX     = 3'(click_idx % 8);
            iClickY     = 3'(click_idx / 8);
            sb_push("start_click_pulse", 32'd0);
        end
        step();
        iStart      = 1'b0;
        iClickValid = 1'b0;
        if (click_idx >= 0) begin
            sb_pop({30'b0, oCorrect, oWrong});
            check("start_click_next", oNextNum, 1);
        end
        for (int i = 0; i < NC; i++) begin
            m_act[i] = 1'b0;
            m_num[i] = 0;
        end
        m_cnt = (count == 0) ? 1 : ((count > 31) ? 31 : count);
        check("clear_busy", {oBusy, oState}, {1'b1, 3'd1});
        n = 0;
        while (oState == 3'd1 && n < 200) begin
            n++;
            step();
        end
        check("clear_cycles", n, 64);
        check("load_entry", {oBusy, oState}, {1'b1, 3'd2});
        k = 1;
        retry = 0;
        cyc = 0;
        while (k <= m_cnt && cyc < 3000) begin
            r = (mode == 1) ? 8'd5 : 8'($urandom);
            iRandNum = r;
            if (cyc == 0) begin
                iClickValid = 1'b1;
                iClickX = 3'd0;
                iClickY = 3'd0;
                sb_push("load_click", 32'd0);
            end
            idx = int'(r[5:3]) * 8 + int'(r[2:0]);
            pidx = -1;
            if (!m_act[idx]) begin
                pidx = idx;
            end else if (retry == 14) begin
                for (int j = 0; j < NC; j++)
                    if (!m_act[j] && pidx < 0)
                        pidx = j;
            end else begin
                retry++;
            end
            if (pidx >= 0) begin
                m_act[pidx] = 1'b1;
                m_num[pidx] = k;
                pos[k] = pidx;
                k++;
                retry = 0;
            end
            step();
            if (cyc == 0) begin
                iClickValid = 1'b0;
                sb_pop({30'b0, oCorrect, oWrong});
            end
            cyc++;
        end
        check("load_show", {oBusy, oState}, {1'b0, 3'd3});
        check("load_next", oNextNum, 1);
    endtask

    initial begin
        int empty, n, p1;
        logic [31:0] mask;
        rst_n = 1'b0;
        iStart = 1'b0; iCount = '0; iRandNum = '0; iClickValid = 1'b0;
        iClickX = '0; iClickY = '0; iRdX = '0; iRdY = '0;
        s_start = 1'b0; s_count = '0; s_rand = '0; s_rdx = '0; s_rdy = '0;
        for (int i = 0; i < NC; i++) begin
            m_act[i] = 1'b0;
            m_num[i] = 0;
        end
        repeat (3) step();
        check("reset_outs",
              {oState, oBusy, oCorrect, oWrong, oWon, oLost, oRdActive, oRdShown, oRdNum},
              '0);
        check("reset_next", oNextNum, 1);
        rst_n = 1'b1;
        step();

        click(0, 0, 0, "idle_click");

        start_round(4, 0, -1);
        rd_all(1'b1);
        empty = 0;
        while (m_act[empty]) empty++;
        click(empty, 0, 0, "empty_click");
        click(pos[1], 1, 0, "win_click1");
        check("hidden_state", oState, 4);
        rd(pos[2], 1'b0, "hidden_rd");
        click(pos[2], 1, 0, "win_click2");
        click(pos[3], 1, 0, "win_click3");
        click(pos[4], 1, 0, "win_click4");
        check("won_flags", {oWon, oLost, oState}, {1'b1, 1'b0, 3'd5});
        check("won_next", oNextNum, 5);
        click(pos[4], 0, 0, "won_click");

        start_round(4, 1, -1);
        rd_all(1'b1);
        click(pos[1], 1, 0, "lose_click1");
        click(pos[3], 0, 1, "lose_click3");
        check("lost_flags", {oWon, oLost, oState}, {1'b0, 1'b1, 3'd6});
        check("lost_next", oNextNum, 2);
        rd(pos[2], 1'b1, "lost_rd2");
        rd(pos[3], 1'b1, "lost_rd3");
        rd(pos[4], 1'b1, "lost_rd4");

        start_round(0, 0, -1);
        rd_all(1'b1);
        click(pos[1], 1, 0, "one_click");
        check("one_won", {oWon, oState}, {1'b1, 3'd5});
        check("one_next", oNextNum, 2);

        start_round(4, 0, -1);
        p1 = pos[1];
        start_round(4, 0, p1);

        iCount = 5'd4;
        iStart = 1'b1;
        step();
        iStart = 1'b0;
        n = 0;
        while (oState != 3'd2 && n < 200) begin
            n++;
            step();
        end
        check("rst_reach_load", oState, 2);
        iRandNum = 8'd9;
        step();
        iClickValid = 1'b1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_load",
              {oState, oBusy, oCorrect, oWrong, oWon, oLost, oRdActive, oRdShown, oRdNum},
              '0);
        check("rst_mid_next", oNextNum, 1);
        iClickValid = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < NC; i++) begin
            m_act[i] = 1'b0;
            m_num[i] = 0;
        end
        rd_all(1'b0);

        s_count = 5'd31;
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        n = 0;
        while (s_state != 3'd3 && n < 500) begin
            s_rand = 8'($urandom);
            n++;
            step();
        end
        check("small_show", s_state, 3);
        mask = '0;
        for (int i = 0; i < 16; i++) begin
            s_rdx = 2'(i % 4);
            s_rdy = 2'(i / 4);
            sb_push("small_cell", 32'd3);
            step();
            sb_pop({30'b0, s_rdact, s_rdshown});
            mask = mask | (32'd1 << s_rdnum);
        end
        check("small_perm", mask, 32'h0001_FFFE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
